axi_ram_slave: RTL
==================

# axi_ram_slave

AXI4 slave front-end for the 64-bit byte-addressed RAM model used in controller bench tests. Accepts INCR write and read bursts from the DDR controller under test, serialises them onto the RAM's single `wr_en`/`rd_en` port and bidirectional 64-bit data bus, and returns B and R responses. This lets the controller be verified end-to-end without a DDR PHY.

## Interface
- `RD_FIFO_DEPTH`, 4: read-return buffer depth in beats; power of two, minimum 4.
- `MEM_BYTES`, 65536: addressable RAM size in bytes; used only under the macro.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `awvalid`/`awready` in/out 1: write address handshake.
- `awaddr` in 30: write burst start byte address, 8-byte aligned.
- `awlen` in 8: write beats minus 1.
- `wdata` in 64: write data.
- `wvalid`/`wready` in/out 1: write data handshake.
- `wlast` in 1: last write beat.
- `bvalid` out 1: write response valid.
- `bready` in 1: write response accepted.
- `bresp` out 2: write response code.
- `arvalid`/`arready` in/out 1: read address handshake.
- `araddr` in 30: read burst start byte address.
- `arlen` in 8: read beats minus 1.
- `rdata` out 64: read data.
- `rvalid` out 1: read data valid.
- `rready` in 1: read data accepted.
- `rlast` out 1: last read beat.
- `rresp` out 2: read response code.
- `ram_wr_en`, `ram_rd_en` out 1: RAM strobes.
- `ram_wr_addr`, `ram_rd_addr` out 30: RAM run base addresses.
- `ram_data` inout 64: RAM data bus.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD, RD_DRAIN. One burst is in progress at a time.
- IDLE arbitration: AW wins over AR when both are valid, unless the previous burst was a write; in that case AR wins (alternating priority).
- Accepting a request latches `addr` and `len`, clears the beat counter, and moves to WR or RD.
- **WR:**
  - `wready` is 1.
  - Each `wvalid & wready` beat asserts `ram_wr_en` in the same cycle and drives `ram_data = wdata`; the bus is Z otherwise.
  - The RAM self-increments by 8 per consecutive `ram_wr_en` cycle.
  - The block tracks the next beat address `cur = addr + 8*beat`. When `ram_wr_en` was 0 in the previous cycle, `ram_wr_addr = cur`. It is held constant while `ram_wr_en` stays high.
  - A `wvalid` gap ends the run; the next beat restarts with the new `cur`.
  - When beat `len` is accepted, go to WR_RESP. `wlast` mismatch sets `bresp = SLVERR`, and the burst still completes `len+1` beats.
- **WR_RESP:** `bvalid` = 1 until `bready`, then IDLE.
- **RD:**
  - `ram_rd_en` is asserted while beats remain to issue and `fifo_count + inflight < RD_FIFO_DEPTH`.
  - The same run-base rule applies to `ram_rd_addr`.
  - `ram_data` is sampled one cycle after each `ram_rd_en` cycle and pushed into the FIFO, tagged with last = (beat == `len`).
  - After all beats are issued, go to RD_DRAIN.
- **RD_DRAIN:** the FIFO head drives `rdata`, `rvalid`, `rlast`. On the pop of the tagged last beat, go to IDLE.
- Widths: the beat counter is 9 bits; address arithmetic is 30 bits and wraps modulo 2^30.

## Timing
- Reset values: all ready/valid/strobe outputs 0; `bresp` = `rresp` = 0 (OKAY); addresses 0; `rdata` 0; `ram_data` Z; FSM IDLE; FIFO empty.
- `awready`/`arready` are 1-cycle pulses in IDLE. A burst starts the cycle after the address handshake.
- Write: zero added latency, 1 beat/cycle sustained. B response follows the last beat by 1 cycle.
- Read: first `rvalid` 2 cycles after the first `ram_rd_en`. With `rready` held high, throughput is 1 beat/cycle.
- `ram_wr_en` and `ram_rd_en` are never high in the same cycle. Bus turnaround needs no idle cycle, since the RAM drives only when `wr_en` = 0.
- Reset mid-burst: everything returns to reset values immediately, the FIFO is flushed, and partial RAM writes remain.

## Configuration
- `AXI_RAM_RANGE_CHECK_EN` defined: a burst with `addr + 8*(len+1) > MEM_BYTES` is flagged out of range:
  - no RAM strobes are issued;
  - writes drain all W beats, then return `bresp` = SLVERR;
  - reads return `len+1` beats with `rdata` = 0 and `rresp` = SLVERR.
- Macro undefined: no check; `MEM_BYTES` is unused.

## Structure
- Package `axi_ram_pkg`: response constants OKAY = 2'b00, SLVERR = 2'b10; FSM state enum; beat size constant 8.
- Sub-module `axi_ram_rd_fifo`: synchronous FIFO, 65 bits wide (data + last), `RD_FIFO_DEPTH` deep, with push/pop/count.

## Test plan
- Write `awaddr` = 0x100, `awlen` = 3, data 0x11..44 back-to-back → `ram_wr_en` high 4 cycles with `ram_wr_addr` = 0x100; then `bvalid`, `bresp` = 0.
- Same write with a 2-cycle `wvalid` gap after beat 1 → second run has `ram_wr_addr` = 0x110; readback is correct.
- Read `araddr` = 0x100, `arlen` = 3, `rready` = 1 → first `rvalid` 2 cycles after the first `ram_rd_en`; 4 beats with `rlast` on the 4th.
- Read `arlen` = 7 with `rready` toggling 1/0 → `ram_rd_en` throttled, no FIFO overflow, data in order.
- AW and AR in the same cycle in IDLE after a write → read is served first.
- Macro on, `awaddr` = 0xFFF8, `awlen` = 1 → no `ram_wr_en`; `bresp` = SLVERR.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: shared definitions for the AXI4 RAM slave front-end.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   BEAT_BYTES              : bytes per 64-bit beat
//   state_e                 : burst-sequencing FSM states
package axi_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BEAT_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_DRAIN
    } state_e;

endpackage

// File: rtl/axi_ram_rd_fifo.sv
// axi_ram_rd_fifo: synchronous read-return FIFO (data + last tag).
//   clk, rst_n : clock, asynchronous active-low reset (flushes pointers/count)
//   push_i     : write data_i into the tail
//   data_i     : {last, data} entry
//   pop_i      : discard the head entry
//   data_o     : head entry (valid when empty_o is 0)
//   count_o    : number of stored entries
//   empty_o    : FIFO holds no entries
module axi_ram_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 INCR-burst slave that serialises bursts onto a
// single-port 64-bit RAM with self-incrementing address and shared data bus.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   aw*/w*/b*                     : AXI write address, data and response channels
//   ar*/r*                        : AXI read address and data channels
//   ram_wr_en / ram_rd_en         : RAM strobes (never both high)
//   ram_wr_addr / ram_rd_addr     : base address of the current strobe run
//   ram_data                      : bidirectional RAM bus (driven here only on writes)
// Optional build macro AXI_RAM_RANGE_CHECK_EN: bursts extending past MEM_BYTES
// issue no RAM strobes and complete with SLVERR (reads return zero data).
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int RD_FIFO_DEPTH = 4,
    parameter int MEM_BYTES     = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [29:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [63:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [29:0] araddr,
    input  logic [7:0]  arlen,
    output logic [63:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast,
    output logic [1:0]  rresp,
    output logic        ram_wr_en,
    output logic        ram_rd_en,
    output logic [29:0] ram_wr_addr,
    output logic [29:0] ram_rd_addr,
    inout  wire  [63:0] ram_data
);

    localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [8:0]  beat_q, beat_d;
    logic        last_wr_q, last_wr_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        oor_q, oor_d;
    logic        wr_en_prev_q, rd_en_prev_q;
    logic [29:0] wr_addr_q, rd_addr_q;
    logic        rd_pend_q, rd_last_pend_q;

    logic        aw_oor, ar_oor;
    logic [29:0] cur;
    logic        last_beat;
    logic        rd_issue, rd_space, rd_pop;
    logic [64:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic        fifo_empty;

`ifdef AXI_RAM_RANGE_CHECK_EN
    assign aw_oor = ({2'b00, awaddr} + 32'(BEAT_BYTES) * (32'(awlen) + 32'd1)) > 32'(MEM_BYTES);
    assign ar_oor = ({2'b00, araddr} + 32'(BEAT_BYTES) * (32'(arlen) + 32'd1)) > 32'(MEM_BYTES);
`else
    logic unused_mem_bytes;
    assign unused_mem_bytes = ^32'(MEM_BYTES);
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Address of the next beat to transfer; wraps modulo 2^30.
    assign cur       = addr_q + 30'(beat_q) * 30'(BEAT_BYTES);
    assign last_beat = (beat_q == {1'b0, len_q});

    // A slot is reserved for the beat whose RAM data arrives next cycle.
    assign rd_space = (32'(fifo_count) + 32'(rd_pend_q)) < 32'(RD_FIFO_DEPTH);

    assign rvalid = ((state_q == RD) || (state_q == RD_DRAIN)) && !fifo_empty;
    assign rd_pop = rvalid && rready;
    assign rdata  = rvalid ? fifo_head[63:0] : 64'd0;
    assign rlast  = rvalid && fifo_head[64];
    assign rresp  = (rvalid && oor_q) ? RESP_SLVERR : RESP_OKAY;
    assign bresp  = bvalid ? bresp_q : RESP_OKAY;

    assign ram_rd_en = rd_issue && !oor_q;

    // The RAM increments its own address during a run, so the base is only
    // refreshed on the first strobe after an idle cycle.
    assign ram_wr_addr = (ram_wr_en && !wr_en_prev_q) ? cur : wr_addr_q;
    assign ram_rd_addr = (ram_rd_en && !rd_en_prev_q) ? cur : rd_addr_q;

    assign ram_data = ram_wr_en ? wdata : 64'bz;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        last_wr_d = last_wr_q;
        bresp_d   = bresp_q;
        oor_d     = oor_q;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        ram_wr_en = 1'b0;
        rd_issue  = 1'b0;
        case (state_q)
            IDLE: begin
                // Alternating priority: a pending read beats a write right after a write.
                if (awvalid && !(last_wr_q && arvalid)) begin
                    awready   = 1'b1;
                    addr_d    = awaddr;
                    len_d     = awlen;
                    beat_d    = 9'd0;
                    last_wr_d = 1'b1;
                    oor_d     = aw_oor;
                    bresp_d   = aw_oor ? RESP_SLVERR : RESP_OKAY;
                    state_d   = WR;
                end else if (arvalid) begin
                    arready   = 1'b1;
                    addr_d    = araddr;
                    len_d     = arlen;
                    beat_d    = 9'd0;
                    last_wr_d = 1'b0;
                    oor_d     = ar_oor;
                    state_d   = RD;
                end
            end
            WR: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_wr_en = !oor_q;
                    // A misplaced wlast flags the burst but the beat count still rules.
                    if (wlast != last_beat) begin
                        bresp_d = RESP_SLVERR;
                    end
                    beat_d = beat_q + 9'd1;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (rd_space) begin
                    rd_issue = 1'b1;
                    beat_d   = beat_q + 9'd1;
                    if (last_beat) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (rd_pop && fifo_head[64]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            last_wr_q      <= 1'b0;
            bresp_q        <= RESP_OKAY;
            oor_q          <= 1'b0;
            wr_en_prev_q   <= 1'b0;
            rd_en_prev_q   <= 1'b0;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            rd_pend_q      <= 1'b0;
            rd_last_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            beat_q         <= beat_d;
            last_wr_q      <= last_wr_d;
            bresp_q        <= bresp_d;
            oor_q          <= oor_d;
            wr_en_prev_q   <= ram_wr_en;
            rd_en_prev_q   <= ram_rd_en;
            wr_addr_q      <= ram_wr_addr;
            rd_addr_q      <= ram_rd_addr;
            rd_pend_q      <= rd_issue;
            rd_last_pend_q <= rd_issue && last_beat;
        end
    end

    // RAM returns data the cycle after a read strobe; capture it then.
    axi_ram_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .WIDTH (65)
    ) u_rd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_pend_q),
        .data_i  ({rd_last_pend_q, (oor_q ? 64'd0 : ram_data)}),
        .pop_i   (rd_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule
